// File: rtl/iobus_mmio_hub.sv
// iobus_mmio_hub: memory-mapped I/O hub for the MCU IOBUS.
// Input ports, output registers, 64-bit cycle counter and interval timer.
module iobus_mmio_hub #(
    parameter int          N_IN        = 2,
    parameter int          N_OUT       = 4,
    parameter int          IN_W        = 16,
    parameter int          OUT_W       = 16,
    parameter logic [31:0] STRIDE      = 32'h0004_0000,
    parameter logic [31:0] IN_BASE_AD  = 32'h1100_0000,
    parameter logic [31:0] OUT_BASE_AD = 32'h1108_0000,
    parameter logic [31:0] CNT_BASE_AD = 32'h1140_0000
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [31:0]            IOBUS_ADDR,
    input  logic [31:0]            IOBUS_OUT,
    input  logic                   IOBUS_WR,
    input  logic                   IOBUS_RD,
    output logic [31:0]            IOBUS_IN,
    input  logic [N_IN*IN_W-1:0]   IN_PORTS,
    output logic [N_OUT*OUT_W-1:0] OUT_PORTS,
    output logic [N_OUT-1:0]       OUT_WSTB,
    output logic                   TMR_INTR
);

    localparam logic [31:0] A_LO    = CNT_BASE_AD;
    localparam logic [31:0] A_HI    = CNT_BASE_AD + 32'h4;
    localparam logic [31:0] A_CTRL  = CNT_BASE_AD + 32'h8;
    localparam logic [31:0] A_TLOAD = CNT_BASE_AD + 32'hC;
    localparam logic [31:0] A_TCNT  = CNT_BASE_AD + 32'h10;

    function automatic logic [31:0] in_ad(int i);
        return IN_BASE_AD + STRIDE * 32'(i);
    endfunction

    function automatic logic [31:0] out_ad(int j);
        return OUT_BASE_AD + STRIDE * 32'(j);
    endfunction

    // Any decoded address shared between two regions is a parameter error.
    function automatic bit regions_overlap();
        bit ov;
        ov = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            for (int j = 0; j < N_OUT; j++)
                if (in_ad(i) == out_ad(j)) ov = 1'b1;
            for (int k = 0; k < 5; k++)
                if (in_ad(i) == CNT_BASE_AD + 32'(4 * k)) ov = 1'b1;
        end
        for (int j = 0; j < N_OUT; j++)
            for (int k = 0; k < 5; k++)
                if (out_ad(j) == CNT_BASE_AD + 32'(4 * k)) ov = 1'b1;
        return ov;
    endfunction

    if (regions_overlap()) begin : g_overlap_err
        $error("iobus_mmio_hub: address regions overlap");
    end

    logic [OUT_W-1:0] out_q [N_OUT];
    logic [OUT_W-1:0] out_d [N_OUT];
    logic [N_OUT-1:0] wstb_q, wstb_d;
    logic [63:0]      cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic             cnt_en_q, cnt_en_d;
    logic             tmr_en_q, tmr_en_d;
    logic [31:0]      tload_q, tload_d;
    logic [31:0]      tcount_q, tcount_d;
    logic             intr_q, intr_d;
    logic             clr;

    // Combinational read mux; unmapped addresses return zero.
    always_comb begin
        IOBUS_IN = '0;
        for (int i = 0; i < N_IN; i++)
            if (IOBUS_ADDR == in_ad(i))
                IOBUS_IN = 32'(IN_PORTS[i*IN_W +: IN_W]);
        for (int j = 0; j < N_OUT; j++)
            if (IOBUS_ADDR == out_ad(j))
                IOBUS_IN = 32'(out_q[j]);
        if (IOBUS_ADDR == A_LO)    IOBUS_IN = cnt_q[31:0];
        if (IOBUS_ADDR == A_HI)    IOBUS_IN = hi_q;
        if (IOBUS_ADDR == A_CTRL)  IOBUS_IN = {30'b0, tmr_en_q, cnt_en_q};
        if (IOBUS_ADDR == A_TLOAD) IOBUS_IN = tload_q;
        if (IOBUS_ADDR == A_TCNT)  IOBUS_IN = tcount_q;
    end

    // Pack output registers onto the flat port.
    always_comb begin
        OUT_PORTS = '0;
        for (int j = 0; j < N_OUT; j++)
            OUT_PORTS[j*OUT_W +: OUT_W] = out_q[j];
    end

    assign OUT_WSTB = wstb_q;
    assign TMR_INTR = intr_q;

    // Next-state: bus writes, snapshot, counter and timer.
    always_comb begin
        out_d    = out_q;
        wstb_d   = '0;
        cnt_en_d = cnt_en_q;
        tmr_en_d = tmr_en_q;
        tload_d  = tload_q;
        tcount_d = tcount_q;
        hi_d     = hi_q;
        intr_d   = 1'b0;
        clr      = 1'b0;
        if (IOBUS_WR) begin
            for (int j = 0; j < N_OUT; j++)
                if (IOBUS_ADDR == out_ad(j)) begin
                    out_d[j]  = IOBUS_OUT[OUT_W-1:0];
                    wstb_d[j] = 1'b1;
                end
            if (IOBUS_ADDR == A_CTRL) begin
                cnt_en_d = IOBUS_OUT[0];
                tmr_en_d = IOBUS_OUT[1];
                clr      = IOBUS_OUT[2];
            end
        end
        if (clr)
            cnt_d = '0;
        else if (cnt_en_q)
            cnt_d = cnt_q + 64'd1;
        else
            cnt_d = cnt_q;
        if (IOBUS_RD && IOBUS_ADDR == A_LO)
            hi_d = cnt_q[63:32];
        if (tmr_en_q && tload_q != '0) begin
            if (tcount_q == '0) begin
                intr_d   = 1'b1;
                tcount_d = tload_q;
            end else begin
                tcount_d = tcount_q - 32'd1;
            end
        end
        // A TLOAD write overrides any decrement or reload this cycle.
        if (IOBUS_WR && IOBUS_ADDR == A_TLOAD) begin
            tload_d  = IOBUS_OUT;
            tcount_d = IOBUS_OUT;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int j = 0; j < N_OUT; j++) out_q[j] <= '0;
            wstb_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            cnt_en_q <= 1'b1;
            tmr_en_q <= 1'b0;
            tload_q  <= '0;
            tcount_q <= '0;
            intr_q   <= 1'b0;
        end else begin
            out_q    <= out_d;
            wstb_q   <= wstb_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            cnt_en_q <= cnt_en_d;
            tmr_en_q <= tmr_en_d;
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
            intr_q   <= intr_d;
        end
    end

endmodule

// File: tb/tb_iobus_mmio_hub.sv
// tb_iobus_mmio_hub: self-checking bench for iobus_mmio_hub.
// Vector table with scoreboard queue, plus counter/timer/reset sequences.
module tb_iobus_mmio_hub;

    localparam logic [31:0] A_LO    = 32'h1140_0000;
    localparam logic [31:0] A_HI    = 32'h1140_0004;
    localparam logic [31:0] A_CTRL  = 32'h1140_0008;
    localparam logic [31:0] A_TLOAD = 32'h1140_000C;
    localparam logic [31:0] A_TCNT  = 32'h1140_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata;
    logic        wr, rd;
    logic [31:0] in_ports;
    logic [63:0] out_ports;
    logic [3:0]  wstb;
    logic        intr;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [63:0] exp_out;
        logic [3:0]  exp_wstb;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    iobus_mmio_hub dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .IOBUS_ADDR (addr),
        .IOBUS_OUT  (wdata),
        .IOBUS_WR   (wr),
        .IOBUS_RD   (rd),
        .IOBUS_IN   (rdata),
        .IN_PORTS   (in_ports),
        .OUT_PORTS  (out_ports),
        .OUT_WSTB   (wstb),
        .TMR_INTR   (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d,
                                logic [63:0] o, logic [3:0] s,
                                logic [31:0] r);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d;
        v.exp_out = o; v.exp_wstb = s; v.exp_rd = r;
        return v;
    endfunction

    initial begin
        vec_t e;
        int   pulses;
        int   last;
        vecs[0] = mk(1, 32'h110C0000, 32'hABCD1234,
                     64'h0000_0000_1234_0000, 4'b0010, 32'h1234);
        vecs[1] = mk(1, 32'h11080000, 32'hFFFF5678,
                     64'h0000_0000_1234_5678, 4'b0001, 32'h5678);
        vecs[2] = mk(1, 32'h11080000, 32'h00000077,
                     64'h0000_0000_1234_0077, 4'b0001, 32'h0077);
        vecs[3] = mk(1, 32'h11140000, 32'h0000BEEF,
                     64'hBEEF_0000_1234_0077, 4'b1000, 32'hBEEF);
        vecs[4] = mk(1, 32'h11000000, 32'h00001111,
                     64'hBEEF_0000_1234_0077, 4'b0000, 32'h3C3C);
        vecs[5] = mk(1, 32'h11040000, 32'h00002222,
                     64'hBEEF_0000_1234_0077, 4'b0000, 32'hA5A5);
        vecs[6] = mk(1, 32'h11080004, 32'h00009999,
                     64'hBEEF_0000_1234_0077, 4'b0000, 32'h0);
        vecs[7] = mk(1, 32'h11100000, 32'h00000042,
                     64'hBEEF_0042_1234_0077, 4'b0100, 32'h0042);
        vecs[8] = mk(0, 32'h11180000, 32'h00005555,
                     64'hBEEF_0042_1234_0077, 4'b0000, 32'h0);
        vecs[9] = mk(1, A_TCNT, 32'h00000007,
                     64'hBEEF_0042_1234_0077, 4'b0000, 32'h0);

        rst_n = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = '0; wdata = '0;
        in_ports = {16'hA5A5, 16'h3C3C};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        addr = 32'h11080000;
        #1;
        check("rst_out0_rd", 64'(rdata), 64'h0);
        check("rst_out_ports", out_ports, 64'h0);
        check("rst_wstb", 64'(wstb), 64'h0);
        check("rst_intr", 64'(intr), 64'h0);
        addr = A_CTRL;
        #1;
        check("rst_ctrl", 64'(rdata), 64'h1);
        rst_n = 1'b1;

        // Register writes and decode via table + scoreboard
        for (int i = 0; i < 10; i++) begin
            wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].data;
            sb.push_back(vecs[i]);
            step();
            e = sb.pop_front();
            check($sformatf("vec%0d_out", i), out_ports, e.exp_out);
            check($sformatf("vec%0d_wstb", i), 64'(wstb), 64'(e.exp_wstb));
            check($sformatf("vec%0d_rd", i), 64'(rdata), 64'(e.exp_rd));
        end
        wr = 1'b0;
        check("sb_empty", 64'(sb.size()), 64'h0);
        step();
        check("wstb_idle", 64'(wstb), 64'h0);

        // Coherent snapshot across a LO wrap
        force dut.cnt_q = 64'h0000_0004_FFFF_FFFE;
        #1;
        release dut.cnt_q;
        addr = A_LO; rd = 1'b1;
        #1;
        check("snap_lo", 64'(rdata), 64'hFFFF_FFFE);
        step();
        rd = 1'b0;
        step();
        #1;
        check("snap_lo_live", 64'(rdata), 64'h0);
        addr = A_HI;
        #1;
        check("snap_hi", 64'(rdata), 64'h4);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("snap_hi_rd_noupd", 64'(rdata), 64'h4);

        // Interval timer: period TLOAD+1
        wr = 1'b1; addr = A_TLOAD; wdata = 32'd3;
        step();
        addr = A_CTRL; wdata = 32'h3;
        step();
        wr = 1'b0; addr = A_TCNT;
        pulses = 0; last = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (intr) begin
                if (pulses == 0) check("tmr_first", 64'(k), 64'd4);
                else check("tmr_gap", 64'(k - last), 64'd4);
                pulses++;
                last = k;
            end
        end
        check("tmr_pulses", 64'(pulses), 64'd6);
        wr = 1'b1; addr = A_CTRL; wdata = 32'h1;
        step();
        wr = 1'b0; addr = A_TCNT;
        #1;
        check("tmr_frozen_val", 64'(rdata), 64'd2);
        pulses = 0;
        repeat (8) begin
            step();
            if (intr) pulses++;
        end
        check("tmr_off_pulses", 64'(pulses), 64'd0);
        check("tmr_frozen_hold", 64'(rdata), 64'd2);

        // Counter clear and 64-bit wrap
        wr = 1'b1; addr = A_CTRL; wdata = 32'h5;
        step();
        wr = 1'b0;
        #1;
        check("ctrl_clr_not_stored", 64'(rdata), 64'h1);
        addr = A_LO;
        #1;
        check("clr_lo0", 64'(rdata), 64'h0);
        step();
        check("clr_lo1", 64'(rdata), 64'h1);
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cnt_q;
        rd = 1'b1;
        #1;
        check("wrap_lo_max", 64'(rdata), 64'hFFFF_FFFF);
        step();
        check("wrap_lo0", 64'(rdata), 64'h0);
        step();
        rd = 1'b0; addr = A_HI;
        #1;
        check("wrap_hi0", 64'(rdata), 64'h0);

        // Reset mid-timer dominates a concurrent write
        wr = 1'b1; addr = 32'h11080000; wdata = 32'h00FF;
        step();
        addr = A_TLOAD; wdata = 32'd2;
        step();
        addr = A_CTRL; wdata = 32'h3;
        step();
        wr = 1'b0;
        repeat (3) step();
        check("pre_rst_reg0", 64'(out_ports[15:0]), 64'h00FF);
        rst_n = 1'b0;
        wr = 1'b1; addr = 32'h11080000; wdata = 32'h1234;
        step();
        wr = 1'b0;
        check("mid_rst_out", out_ports, 64'h0);
        check("mid_rst_wstb", 64'(wstb), 64'h0);
        check("mid_rst_intr", 64'(intr), 64'h0);
        addr = A_TCNT;
        #1;
        check("mid_rst_tcount", 64'(rdata), 64'h0);
        addr = A_TLOAD;
        #1;
        check("mid_rst_tload", 64'(rdata), 64'h0);
        addr = A_CTRL;
        #1;
        check("mid_rst_ctrl", 64'(rdata), 64'h1);
        addr = A_LO;
        #1;
        check("mid_rst_lo", 64'(rdata), 64'h0);
        addr = 32'h11500000;
        #1;
        check("unmapped", 64'(rdata), 64'h0);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
